// File: rtl/adder_bist_driver.sv
// Self-test driver for a combinational WIDTH-bit adder: applies 4 directed vectors
// and then LFSR vectors, and checks each result against a golden a+b+cin.
module adder_bist_driver #(
    parameter int          WIDTH       = 16,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'h1ACE_B00C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [15:0] PAT_A     = 16'hAAAA;
    localparam logic [15:0] PAT_B     = 16'h5555;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);

    state_t          state_q;
    logic [15:0]     idx_q;
    logic [31:0]     lfsr_q;

    logic [15:0]     vec_k;
    logic [WIDTH-1:0] a_d, b_d;
    logic            cin_d;
    logic [31:0]     lfsr_d;
    logic [WIDTH:0]  exp_res;
    logic            mismatch;
    logic [15:0]     err_d, ffi_d;

    always_comb begin
        // Index of the vector that the next edge will place on a/b/cin.
        vec_k  = (state_q == RUN) ? idx_q + 16'd1 : 16'd0;
        a_d    = '0;
        b_d    = '0;
        cin_d  = 1'b0;
        lfsr_d = lfsr_q;
        case (vec_k)
            16'd0: begin
                a_d   = '0;
                b_d   = '0;
                cin_d = 1'b0;
            end
            16'd1: begin
                a_d   = '1;
                b_d   = {{(WIDTH-1){1'b0}}, 1'b1};
                cin_d = 1'b0;
            end
            16'd2: begin
                a_d   = '1;
                b_d   = '1;
                cin_d = 1'b1;
            end
            16'd3: begin
                a_d   = PAT_A[WIDTH-1:0];
                b_d   = PAT_B[WIDTH-1:0];
                cin_d = 1'b1;
            end
            default: begin
                a_d    = lfsr_q[WIDTH-1:0];
                b_d    = lfsr_q[16 +: WIDTH];
                cin_d  = lfsr_q[31] ^ lfsr_q[0];
                lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
            end
        endcase

        exp_res  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        mismatch = (exp_res[WIDTH-1:0] != sum) || (exp_res[WIDTH] != cout);
        err_d    = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        ffi_d    = (mismatch && first_fail_idx == 16'hFFFF) ? idx_q : first_fail_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 16'd0;
            lfsr_q         <= SEED_EFF;
            a              <= '0;
            b              <= '0;
            cin            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_idx <= 16'hFFFF;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= RUN;
                        idx_q          <= 16'd0;
                        lfsr_q         <= SEED_EFF;
                        a              <= a_d;
                        b              <= b_d;
                        cin            <= cin_d;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= 16'd0;
                        first_fail_idx <= 16'hFFFF;
                    end
                end
                RUN: begin
                    err_count      <= err_d;
                    first_fail_idx <= ffi_d;
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        a       <= '0;
                        b       <= '0;
                        cin     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_d == 16'd0);
                    end else begin
                        idx_q  <= idx_q + 16'd1;
                        lfsr_q <= lfsr_d;
                        a      <= a_d;
                        b      <= b_d;
                        cin    <= cin_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: drives it against an in-bench adder with optional
// stuck-at faults and checks vector sequence, timing and reported results.
module tb_adder_bist_driver;

    localparam int          W    = 16;
    localparam int          NV   = 256;
    localparam logic [31:0] SEED = 32'h1ACE_B00C;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [W-1:0]  a, b, sum;
    logic          cin, cout, busy, done, pass;
    logic [15:0]   err_count, first_fail_idx;
    int            fault_mode;
    logic [W:0]    true_res;

    // 0 = ideal adder, 1 = cout stuck-at-0, 2 = sum[7] stuck-at-1
    always_comb begin
        true_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum      = true_res[W-1:0];
        cout     = true_res[W];
        if (fault_mode == 1) cout = 1'b0;
        if (fault_mode == 2) sum[7] = 1'b1;
    end

    adder_bist_driver #(.WIDTH(W), .NUM_VECTORS(NV), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } dir_t;

    dir_t         dir_tbl[4];
    logic [32:0]  exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_model();
        logic [31:0] lfsr;
        lfsr = SEED;
        exp_q.delete();
        for (int k = 0; k < NV; k++) begin
            if (k < 4) begin
                exp_q.push_back({dir_tbl[k].a, dir_tbl[k].b, dir_tbl[k].cin});
            end else begin
                exp_q.push_back({lfsr[15:0], lfsr[31:16], lfsr[31] ^ lfsr[0]});
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_a"},    32'(a), 32'h0);
        check({tag, "_b"},    32'(b), 32'h0);
        check({tag, "_cin"},  32'(cin), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_err"},  32'(err_count), 32'h0);
        check({tag, "_ffi"},  32'(first_fail_idx), 32'hFFFF);
    endtask

    // Full run: start pulse, NV cycles of vector/busy checks, then final results.
    task automatic run(input int fault, input bit extra_start, input bit chk_dir);
        int          exp_err, vec_bad, busy_bad, done_bad;
        logic [15:0] exp_ffi;
        logic [15:0] ta, tb;
        logic        tc, fc;
        logic [16:0] tr;
        logic [15:0] fs;
        exp_err = 0;
        exp_ffi = 16'hFFFF;
        for (int k = 0; k < NV; k++) begin
            {ta, tb, tc} = exp_q[k];
            tr = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
            fs = tr[15:0];
            fc = tr[16];
            if (fault == 1) fc = 1'b0;
            if (fault == 2) fs[7] = 1'b1;
            if (fs != tr[15:0] || fc != tr[16]) begin
                exp_err++;
                if (exp_ffi == 16'hFFFF) exp_ffi = 16'(k);
            end
        end
        fault_mode = fault;
        vec_bad = 0; busy_bad = 0; done_bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_err_clr", 32'(err_count), 32'h0);
        check("start_ffi_clr", 32'(first_fail_idx), 32'hFFFF);
        for (int j = 0; j < NV; j++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if ({a, b, cin} !== exp_q[j]) begin
                if (vec_bad == 0) $display("note: vector %0d differs: %0h/%0h/%0b", j, a, b, cin);
                vec_bad++;
            end
            if (chk_dir && j < 4) begin
                check("dir_a",    32'(a),    32'(dir_tbl[j].a));
                check("dir_b",    32'(b),    32'(dir_tbl[j].b));
                check("dir_cin",  32'(cin),  32'(dir_tbl[j].cin));
                check("dir_sum",  32'(sum),  32'(dir_tbl[j].sum));
                check("dir_cout", 32'(cout), 32'(dir_tbl[j].cout));
            end
            start = (extra_start && (j == 50 || j == 120)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles_bad", 32'(busy_bad), 32'h0);
        check("done_early_bad",  32'(done_bad), 32'h0);
        check("vector_seq_bad",  32'(vec_bad), 32'h0);
        check("end_done", 32'(done), 32'h1);
        check("end_busy", 32'(busy), 32'h0);
        check("end_pass", 32'(pass), 32'(exp_err == 0));
        check("end_err",  32'(err_count), 32'(exp_err));
        check("end_ffi",  32'(first_fail_idx), 32'(exp_ffi));
        check("end_a_zero", 32'(a), 32'h0);
    endtask

    initial begin
        dir_tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        dir_tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        dir_tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        dir_tbl[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        build_model();

        rst = 1'b1; start = 1'b0; fault_mode = 0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        run(0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("hold_done", 32'(done), 32'h1);
        check("hold_pass", 32'(pass), 32'h1);
        check("hold_ffi",  32'(first_fail_idx), 32'hFFFF);

        run(1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0);
        check("sum7_err_nonzero", 32'(err_count > 16'd0), 32'h1);
        run(0, 1'b1, 1'b0);

        // Abort a run with reset, including start held during reset.
        fault_mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check_reset("abort");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_wins");
        run(0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bist_driver.md
Name: adder_bist_driver

Overview:
- Synthesizable stimulus generator and response checker for the 16-bit carry-increment adder; it is the driving and checking end of the adder's a/b/cin → sum/cout interface.
- Applies directed corner vectors, then pseudo-random vectors, to a combinational adder.
- Compares each result against an internal golden a+b+cin and reports pass/fail, error count and the first failing vector index.
- Sits beside the adder in FPGA self-test builds and in simulation benches.

Parameters:
- WIDTH, 16, adder operand width; legal range 4..16.
- NUM_VECTORS, 256, total vectors per run including the 4 directed ones; legal range 4..65535.
- SEED, 32'h1ACE_B00C, initial LFSR value; a value of 0 is replaced by 32'h1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin a run.
- a  output  WIDTH  operand A to the adder (registered).
- b  output  WIDTH  operand B to the adder (registered).
- cin  output  1  carry-in to the adder (registered).
- sum  input  WIDTH  adder sum, combinational from a/b/cin.
- cout  input  1  adder carry-out.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  16  number of mismatching vectors, saturates at 16'hFFFF.
- first_fail_idx  output  16  index of the first mismatching vector; 16'hFFFF if none.

Behaviour:
- Reset (async, immediate):
  - State enters IDLE.
  - a, b, cin, busy, done and pass go to 0; err_count goes to 0; first_fail_idx goes to 16'hFFFF.
  - Vector index goes to 0 and the LFSR is loaded with SEED.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start is sampled high.
  - RUN → DONE at the edge that compares vector NUM_VECTORS-1.
  - DONE → RUN when start is sampled high. This clears the counters, reloads the LFSR and sets first_fail_idx to FFFF.
  - start is ignored while in RUN.
- Vector k is placed on a/b/cin at the edge that enters RUN (k=0) or that compares k-1. It is compared at the next edge, so sum/cout must settle within one clock.
- Latency: done rises exactly NUM_VECTORS cycles after the edge that samples start.
- Directed vectors, in order:
  - k=0: (0, 0, 0)
  - k=1: (all-ones, 1, 0)
  - k=2: (all-ones, all-ones, 1)
  - k=3: (0xAAAA truncated to WIDTH, 0x5555 truncated to WIDTH, 1)
- Random vectors for k≥4:
  - LFSR is a 32-bit Galois with polynomial x^32+x^22+x^2+x+1; it advances once per random vector.
  - a = lfsr[WIDTH-1:0]
  - b = lfsr[WIDTH+15:16]
  - cin = lfsr[31]^lfsr[0]
- Golden check:
  - Expected result is a (WIDTH+1)-bit value, {exp_cout, exp_sum} = a + b + cin, computed with zero extension.
  - A mismatch is exp_sum≠sum or exp_cout≠cout.
  - On a mismatch, err_count increments (saturating). first_fail_idx is loaded with k only if it currently equals FFFF.
- Outputs in IDLE/DONE: a, b and cin are driven to 0.
  - err_count and first_fail_idx hold their values until the next start or reset.
  - pass is registered when entering DONE.
- Reset mid-RUN: the run is aborted and all outputs return to reset values. No partial result is reported.
- start coincident with reset: reset wins.

Test Plan:
- Ideal adder model, NUM_VECTORS=256, start pulse at cycle 10:
  - busy=1 for cycles 11..266, done=1 from cycle 267.
  - pass=1, err_count=0, first_fail_idx=FFFF.
- Directed vector check: probe the first 4 applied vectors.
  - Expect (0000,0000,0) → sum 0000, cout 0.
  - Expect (FFFF,0001,0) → sum 0000, cout 1.
  - Expect (FFFF,FFFF,1) → sum FFFF, cout 1.
  - Expect (AAAA,5555,1) → sum 0000, cout 1.
- Faulty adder with cout stuck-at-0:
  - first_fail_idx=1, pass=0.
  - err_count equals the number of applied vectors whose true carry is 1; the bench computes this independently.
- Faulty adder with sum[7] stuck-at-1: first_fail_idx=0, pass=0, err_count>0.
- Assert reset at cycle 100 of a run, then start again:
  - Outputs are at reset values immediately.
  - The second run reproduces an identical vector sequence (same SEED) and pass=1.
- Extra start pulses mid-RUN are ignored (done timing unchanged).
- A start pulse in DONE begins a new run with err_count=0 and first_fail_idx=FFFF.
